// File: rtl/accu_avg_buffer.sv
// accu_avg_buffer
//   Output buffer behind the 4-sample accumulator. Each 10-bit group sum is
//   captured on its valid pulse and stored in a small first-word-fall-through
//   FIFO. The group mean (sum/4) of the head entry is presented over a
//   valid/ready handshake. If a sum arrives while the FIFO is full and nothing
//   is being popped, it is dropped and the sticky overflow flag is set.
//
//   Optional build macro: ACCU_AVG_ROUND_EN
//     defined   -> the mean rounds to nearest: (sum + 2) >> 2
//     undefined -> the mean truncates: sum >> 2
//
//   The reset input keeps the name rst_n for pin compatibility, but it is
//   ACTIVE-HIGH and asynchronous.

module accu_avg_buffer #(
  parameter int DEPTH = 4,
  parameter int SUM_W = 10,
  parameter int AVG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [SUM_W-1:0]             data_in,
  input  logic                         ready_out,
  output logic                         valid_out,
  output logic [AVG_W-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // Storage is not reset. Its contents are never visible while the FIFO is empty.
  logic [SUM_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic [SUM_W-1:0] head;
  logic [AVG_W-1:0] mean;
  logic             push;
  logic             pop;
  logic             drop;

  // Handshake qualifiers. A full FIFO still accepts a sum when a pop frees
  // a slot in the same cycle.
  always_comb begin
    pop  = valid_out & ready_out;
    push = valid_in & (~full | pop);
    drop = valid_in & full & ~pop;
  end

  // Occupancy is tracked separately from the pointers. A push and a pop in
  // the same cycle leave it unchanged.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  // Write the incoming sum into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer advance. Both pointers are log2(DEPTH) bits and wrap naturally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Registered level and status flags, all derived from the next occupancy,
  // so no input has a combinational path to an output.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      level     <= '0;
      valid_out <= 1'b0;
      full      <= 1'b0;
    end else begin
      level     <= level_nxt;
      valid_out <= (level_nxt != '0);
      full      <= (level_nxt == LVL_FULL);
    end
  end

  // Sticky overflow. If a sum is dropped in the same cycle as a clear
  // request, the set takes priority so the drop is not lost.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Mean of the registered head entry. The rounding variant widens by one
  // bit so that adding 2 cannot wrap. The worst case is 1022 >> 2 = 255, so
  // the result needs no saturation.
`ifdef ACCU_AVG_ROUND_EN
  logic [SUM_W:0] rnd;
  always_comb begin
    head = mem[rd_ptr];
    rnd  = {1'b0, head} + (SUM_W + 1)'(2);
    mean = AVG_W'(rnd >> 2);
  end
`else
  always_comb begin
    head = mem[rd_ptr];
    mean = AVG_W'(head >> 2);
  end
`endif

  // data_out is forced to zero while the FIFO is empty, so uninitialised
  // storage never reaches the output.
  always_comb begin
    data_out = valid_out ? mean : '0;
  end

endmodule

// File: tb/tb_accu_avg_buffer.sv
// Directed bench for accu_avg_buffer. Expected values are hand-computed.
// Inputs are driven 1 ns after a rising edge. Outputs are sampled at the same
// point, after the edge has taken effect.

module tb_accu_avg_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [9:0] data_in;
  logic       ready_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic [2:0] level;
  logic       full;
  logic       overflow;
  logic       ovf_clr;

  int n_chk = 0;
  int n_err = 0;

`ifdef ACCU_AVG_ROUND_EN
  localparam int MEAN_OF_6 = 2;
`else
  localparam int MEAN_OF_6 = 1;
`endif

  accu_avg_buffer #(.DEPTH(4), .SUM_W(10), .AVG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push of a single sum.
  task automatic push1(input int d);
    valid_in = 1'b1;
    data_in  = 10'(d);
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", data_out, 0);
    rst_n = 1'b0;
    tick();

    // Test 1: one push into an empty FIFO, consumer ready.
    ready_out = 1'b1;
    push1(400);
    chk("t1_valid", valid_out, 1);
    chk("t1_data", data_out, 100);
    chk("t1_level", level, 1);
    tick();
    chk("t1_level_after", level, 0);
    chk("t1_valid_after", valid_out, 0);

    // Test 2: fill under back-pressure, then drain.
    ready_out = 1'b0;
    push1(4);
    chk("t2_first_data", data_out, 1);
    push1(8); push1(12); push1(16);
    chk("t2_level", level, 4);
    chk("t2_full", full, 1);
    chk("t2_data_hold", data_out, 1);
    tick();
    chk("t2_data_stable", data_out, 1);
    chk("t2_valid_stable", valid_out, 1);
    ready_out = 1'b1;
    tick(); chk("t2_out2", data_out, 2);
    tick(); chk("t2_out3", data_out, 3);
    tick(); chk("t2_out4", data_out, 4);
    tick(); chk("t2_empty", valid_out, 0);
    chk("t2_level_empty", level, 0);

    // Test 3: drop while full, clear, then drop and clear in the same cycle.
    ready_out = 1'b0;
    push1(40); push1(80); push1(120); push1(160);
    push1(1020);
    chk("t3_ovf", overflow, 1);
    chk("t3_level", level, 4);
    chk("t3_head", data_out, 10);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    ovf_clr = 1'b1; push1(1020); ovf_clr = 1'b0;
    chk("t3_set_wins", overflow, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t3_ovf_clr2", overflow, 0);

    // Test 4: full, with a push and a pop in the same cycle.
    ready_out = 1'b1;
    push1(1020);
    chk("t4_level", level, 4);
    chk("t4_full", full, 1);
    chk("t4_head", data_out, 20);
    chk("t4_ovf", overflow, 0);
    tick(); chk("t4_out30", data_out, 30);
    tick(); chk("t4_out40", data_out, 40);
    tick(); chk("t4_out255", data_out, 255);
    chk("t4_level1", level, 1);
    tick(); chk("t4_empty", valid_out, 0);

    // Test 5: truncating versus rounding mean.
    ready_out = 1'b0;
    push1(6);
    chk("t5_mean6", data_out, MEAN_OF_6);
    ready_out = 1'b1; tick(); ready_out = 1'b0;
    push1(1020);
    chk("t5_mean1020", data_out, 255);
    ready_out = 1'b1; tick(); ready_out = 1'b0;
    chk("t5_empty", valid_out, 0);

    // Test 6: asynchronous reset mid-stream with level 3 and overflow set.
    push1(100); push1(200); push1(300); push1(400);
    push1(500);
    chk("t6_ovf_pre", overflow, 1);
    ready_out = 1'b1; tick(); ready_out = 1'b0;
    chk("t6_level_pre", level, 3);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_async_valid", valid_out, 0);
    chk("t6_async_level", level, 0);
    chk("t6_async_ovf", overflow, 0);
    chk("t6_async_data", data_out, 0);
    tick();
    rst_n = 1'b0;
    tick();
    push1(52);
    chk("t6_post_valid", valid_out, 1);
    chk("t6_post_data", data_out, 13);
    chk("t6_post_level", level, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
